// File: rtl/mem_arb_pkg.sv
// Shared types and legal-range constants for the fetch/LSU memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_LS
  } owner_t;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_t;

  localparam int unsigned MEM_LAT_MIN    = 1;
  localparam int unsigned MEM_LAT_MAX    = 4;
  localparam int unsigned STARVE_MAX_MIN = 1;
  localparam int unsigned STARVE_MAX_MAX = 15;

  // Counter widths sized for the largest legal parameter values.
  localparam int unsigned LAT_CNT_W    = $clog2(MEM_LAT_MAX + 1);
  localparam int unsigned STARVE_CNT_W = $clog2(STARVE_MAX_MAX + 1);

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and the load/store unit.
// LS has priority; fetch is forced through after STARVE_MAX consecutive losses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                fetch_stall
);

  localparam logic [LAT_CNT_W-1:0]    LatOne    = LAT_CNT_W'(1);
  localparam logic [LAT_CNT_W-1:0]    LatLoad   = LAT_CNT_W'(MEM_LAT);
  localparam logic [STARVE_CNT_W-1:0] StarveTop = STARVE_CNT_W'(STARVE_MAX);
  localparam logic [STARVE_CNT_W-1:0] StarveOne = STARVE_CNT_W'(1);

  arb_state_t                state_q, state_d;
  owner_t                    owner_q, owner_d;
  logic [LAT_CNT_W-1:0]      lat_cnt_q, lat_cnt_d;
  logic [STARVE_CNT_W-1:0]   starve_cnt_q, starve_cnt_d;

  logic resp, can_issue, starved, if_win, ls_win, issue;

  always_comb begin
    resp      = (state_q == BUSY) && (lat_cnt_q == LatOne);
    // rst gates issue so that no grant or memory strobe leaks out while reset is held.
    can_issue = rst && ((state_q == IDLE) || resp);
    starved   = (starve_cnt_q == StarveTop);
    if_win    = can_issue && if_req && (!ls_req || starved);
    ls_win    = can_issue && ls_req && !if_win;
    issue     = if_win || ls_win;
  end

  always_comb begin
    if_gnt      = if_win;
    ls_gnt      = ls_win;
    fetch_stall = if_req && !if_win;
    mem_en      = issue;
    mem_we      = ls_win && ls_we;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_wstrb   = '0;
    if (ls_win) begin
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
      mem_wstrb = ls_wstrb;
    end else if (if_win) begin
      mem_addr  = if_addr;
    end
    if_rvalid = resp && (owner_q == OWN_IF);
    ls_rvalid = resp && (owner_q == OWN_LS);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    ls_rdata  = ls_rvalid ? mem_rdata : '0;
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    if (issue) begin
      state_d   = BUSY;
      owner_d   = if_win ? OWN_IF : OWN_LS;
      lat_cnt_d = LatLoad;
    end else if (resp) begin
      state_d   = IDLE;
      owner_d   = OWN_NONE;
      lat_cnt_d = '0;
    end else if (state_q == BUSY) begin
      lat_cnt_d = lat_cnt_q - LatOne;
    end
    if (if_win) begin
      starve_cnt_d = '0;
    end else if (if_req && ls_win && !starved) begin
      starve_cnt_d = starve_cnt_q + StarveOne;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_NONE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed sequences, a cycle table for the
// starvation round, and a random phase against a queue-based reference model.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned MEM_LAT    = 2;
  localparam int unsigned STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic [3:0]  ls_wstrb = '0;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        fetch_stall;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MEM_LAT    (MEM_LAT),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_gnt      (if_gnt),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .ls_req      (ls_req),
    .ls_we       (ls_we),
    .ls_addr     (ls_addr),
    .ls_wdata    (ls_wdata),
    .ls_wstrb    (ls_wstrb),
    .ls_gnt      (ls_gnt),
    .ls_rvalid   (ls_rvalid),
    .ls_rdata    (ls_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_rdata   (mem_rdata),
    .fetch_stall (fetch_stall)
  );

  function automatic logic [31:0] seed(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] st);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // Memory macro: write at the issue edge, read data appears MEM_LAT cycles after issue.
  logic [31:0] mem     [256];
  logic [31:0] rd_pipe [MEM_LAT];
  bit          seeded = 1'b0;

  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 256; i++) mem[i] = seed(i);
      seeded = 1'b1;
    end
    rd_pipe[0] <= mem[mem_addr[9:2]];
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_en && mem_we) mem[mem_addr[9:2]] = merge(mem[mem_addr[9:2]], mem_wdata, mem_wstrb);
  end
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  // Expected memory contents, maintained only from the bench's own requests.
  logic [31:0] ref_mem [256];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Called at the negedge of a grant cycle; drops requests and checks the single response.
  task automatic wait_resp(input bit is_ls, input logic [31:0] exp, input bit chkd,
                           input string nm);
    for (int i = 1; i < MEM_LAT; i++) begin
      next_cycle();
      if_req = 1'b0;
      ls_req = 1'b0;
      @(negedge clk);
      chk({nm, "_early"}, is_ls ? ls_rvalid : if_rvalid, 1'b0);
    end
    next_cycle();
    if_req = 1'b0;
    ls_req = 1'b0;
    @(negedge clk);
    chk({nm, "_rvalid"}, is_ls ? ls_rvalid : if_rvalid, 1'b1);
    if (chkd) chk({nm, "_rdata"}, is_ls ? ls_rdata : if_rdata, exp);
    next_cycle();
    @(negedge clk);
    chk({nm, "_once"}, is_ls ? ls_rvalid : if_rvalid, 1'b0);
  endtask

  // Starvation round with both requesters held: {ir, lr, if_gnt, ls_gnt, if_rv, ls_rv, stall}
  typedef struct packed {
    logic ir, lr, eig, elg, eir, elr, efs;
  } vec_t;
  vec_t tbl [13];

  typedef struct {
    int          due;
    bit          is_ls;
    bit          is_store;
    logic [31:0] data;
  } resp_t;
  resp_t pend [$];

  int          cyc, starve;
  bit          resp_now, can_iss, e_ig, e_lg, e_ir, e_lr, last_ig, last_lg;
  logic [31:0] prior, exp_word;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
    tbl[0]  = 7'b11_01001;
    tbl[1]  = 7'b11_00001;
    tbl[2]  = 7'b11_01011;
    tbl[3]  = 7'b11_00001;
    tbl[4]  = 7'b11_01011;
    tbl[5]  = 7'b11_00001;
    tbl[6]  = 7'b11_01011;
    tbl[7]  = 7'b11_00001;
    tbl[8]  = 7'b11_10010;
    tbl[9]  = 7'b11_00001;
    tbl[10] = 7'b11_01101;
    tbl[11] = 7'b00_00000;
    tbl[12] = 7'b00_00010;

    // Reset held with a fetch pending: everything quiet except fetch_stall.
    if_req  = 1'b1;
    if_addr = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_if_gnt", if_gnt, 1'b0);
    chk("rst_ls_gnt", ls_gnt, 1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_if_rvalid", if_rvalid, 1'b0);
    chk("rst_ls_rvalid", ls_rvalid, 1'b0);
    chk("rst_fetch_stall", fetch_stall, 1'b1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("boot_if_gnt", if_gnt, 1'b1);
    chk("boot_mem_en", mem_en, 1'b1);
    chk("boot_mem_addr", mem_addr, 32'h0);
    chk("boot_fetch_stall", fetch_stall, 1'b0);
    wait_resp(1'b0, ref_mem[0], 1'b1, "boot");

    // Partial store followed by a load of the same word.
    next_cycle();
    prior    = ref_mem[128];
    exp_word = {prior[31:16], 16'hBEEF};
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 32'h200;
    ls_wdata = 32'hDEAD_BEEF;
    ls_wstrb = 4'b0011;
    @(negedge clk);
    chk("st_gnt", ls_gnt, 1'b1);
    chk("st_mem_we", mem_we, 1'b1);
    chk("st_mem_addr", mem_addr, 32'h200);
    chk("st_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("st_mem_wstrb", mem_wstrb, 4'b0011);
    wait_resp(1'b1, 32'h0, 1'b0, "st");
    ref_mem[128] = exp_word;
    next_cycle();
    ls_req = 1'b1;
    ls_we  = 1'b0;
    @(negedge clk);
    chk("ld_gnt", ls_gnt, 1'b1);
    chk("ld_mem_we", mem_we, 1'b0);
    wait_resp(1'b1, exp_word, 1'b1, "ld");

    // Starvation round from a cleared starve count.
    next_cycle();
    ls_we   = 1'b0;
    ls_addr = 32'h100;
    if_addr = 32'h40;
    for (int r = 0; r < 13; r++) begin
      if_req = tbl[r].ir;
      ls_req = tbl[r].lr;
      @(negedge clk);
      chk($sformatf("tbl%0d_if_gnt", r), if_gnt, tbl[r].eig);
      chk($sformatf("tbl%0d_ls_gnt", r), ls_gnt, tbl[r].elg);
      chk($sformatf("tbl%0d_if_rvalid", r), if_rvalid, tbl[r].eir);
      chk($sformatf("tbl%0d_ls_rvalid", r), ls_rvalid, tbl[r].elr);
      chk($sformatf("tbl%0d_fetch_stall", r), fetch_stall, tbl[r].efs);
      next_cycle();
    end

    // Reset one cycle after an LS grant drops the access.
    ls_req  = 1'b1;
    ls_we   = 1'b0;
    ls_addr = 32'h300;
    @(negedge clk);
    chk("fly_gnt", ls_gnt, 1'b1);
    next_cycle();
    ls_req = 1'b0;
    rst    = 1'b0;
    @(negedge clk);
    chk("fly_mem_en", mem_en, 1'b0);
    for (int i = 0; i < int'(MEM_LAT) + 1; i++) begin
      next_cycle();
      @(negedge clk);
      chk("fly_no_rvalid", ls_rvalid, 1'b0);
    end
    next_cycle();
    rst     = 1'b1;
    if_req  = 1'b1;
    if_addr = 32'h8;
    @(negedge clk);
    chk("fly_rel_gnt", if_gnt, 1'b1);
    chk("fly_rel_addr", mem_addr, 32'h8);
    wait_resp(1'b0, ref_mem[2], 1'b1, "fly_rel");

    // Random traffic against the reference model.
    next_cycle();
    rst    = 1'b0;
    if_req = 1'b0;
    ls_req = 1'b0;
    next_cycle();
    rst     = 1'b1;
    pend.delete();
    cyc     = 0;
    starve  = 0;
    last_ig = 1'b0;
    last_lg = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (!if_req || last_ig) begin
        if_req  = ($urandom_range(0, 99) < 70);
        if_addr = 32'($urandom_range(0, 255)) << 2;
      end
      if (!ls_req || last_lg) begin
        ls_req   = ($urandom_range(0, 99) < 75);
        ls_we    = ($urandom_range(0, 2) == 0);
        ls_addr  = 32'($urandom_range(0, 255)) << 2;
        ls_wdata = $urandom;
        ls_wstrb = 4'($urandom_range(0, 15));
      end
      resp_now = (pend.size() > 0) && (pend[0].due == cyc);
      can_iss  = (pend.size() == 0) || resp_now;
      e_ig     = can_iss && if_req && (!ls_req || starve == int'(STARVE_MAX));
      e_lg     = can_iss && ls_req && !e_ig;
      e_ir     = 1'b0;
      e_lr     = 1'b0;
      if (resp_now) begin
        e_ir = !pend[0].is_ls;
        e_lr = pend[0].is_ls;
      end
      @(negedge clk);
      chk("rnd_if_gnt", if_gnt, e_ig);
      chk("rnd_ls_gnt", ls_gnt, e_lg);
      chk("rnd_if_rvalid", if_rvalid, e_ir);
      chk("rnd_ls_rvalid", ls_rvalid, e_lr);
      chk("rnd_fetch_stall", fetch_stall, if_req && !e_ig);
      chk("rnd_mem_en", mem_en, e_ig || e_lg);
      if (e_ir) chk("rnd_if_rdata", if_rdata, pend[0].data);
      if (e_lr && !pend[0].is_store) chk("rnd_ls_rdata", ls_rdata, pend[0].data);
      if (e_ig) begin
        chk("rnd_if_addr", mem_addr, if_addr);
        chk("rnd_if_we", mem_we, 1'b0);
      end
      if (e_lg) begin
        chk("rnd_ls_addr", mem_addr, ls_addr);
        chk("rnd_ls_we", mem_we, ls_we);
        if (ls_we) begin
          chk("rnd_wdata", mem_wdata, ls_wdata);
          chk("rnd_wstrb", mem_wstrb, ls_wstrb);
        end
      end
      if (resp_now) void'(pend.pop_front());
      if (e_ig) pend.push_back('{cyc + int'(MEM_LAT), 1'b0, 1'b0, ref_mem[if_addr[9:2]]});
      if (e_lg) begin
        pend.push_back('{cyc + int'(MEM_LAT), 1'b1, ls_we, ref_mem[ls_addr[9:2]]});
        if (ls_we) ref_mem[ls_addr[9:2]] = merge(ref_mem[ls_addr[9:2]], ls_wdata, ls_wstrb);
      end
      if (e_ig) starve = 0;
      else if (if_req && e_lg && starve < int'(STARVE_MAX)) starve++;
      last_ig = e_ig;
      last_lg = e_lg;
      cyc++;
      next_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
